audio_sample_arbiter: RTL and testbench

- Schedules and arbitrates the stereo sample stream into the audio codec write port.
- Three requesters: background music (valid/ready stream from the music player), score blip, and crash sound; the last two are one-cycle event pulses.
- Issues codec writes only when the codec reports space, and applies fixed priority: crash > score > music.
- Sits between the music player and the audio_codec instance at top level, clocked by CLOCK_50.

---
 rtl/audio_sample_arbiter_pkg.sv | 30 +++
 rtl/audio_sample_arbiter_sfx.sv | 80 ++++++++
 rtl/audio_sample_arbiter.sv | 163 ++++++++++++++++
 tb/tb_audio_sample_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_sample_arbiter_pkg.sv
// audio_pkg: shared types and default constants for the audio sample arbiter.
//   SAMPLE_W         codec sample width per channel
//   AMP_DEF          default effect square-wave amplitude (+/-)
//   *_HALF_DEF       default effect half periods, in written samples
//   *_LEN_DEF        default effect durations, in written samples
//   src_e / state_e  source and FSM encodings (the state doubles as active_src)
package audio_pkg;

  localparam int SAMPLE_W = 28;

  localparam logic [SAMPLE_W-1:0] AMP_DEF = 28'h0200000;
  localparam int SCORE_HALF_DEF = 24;
  localparam int SCORE_LEN_DEF  = 2400;
  localparam int CRASH_HALF_DEF = 96;
  localparam int CRASH_LEN_DEF  = 24000;

  typedef enum logic [1:0] {
    SRC_MUSIC = 2'd0,
    SRC_SCORE = 2'd1,
    SRC_CRASH = 2'd2
  } src_e;

  // Encoded identically to src_e so the state register drives active_src.
  typedef enum logic [1:0] {
    S_MUSIC = 2'd0,
    S_SCORE = 2'd1,
    S_CRASH = 2'd2
  } state_e;

endpackage

// File: rtl/audio_sample_arbiter_sfx.sv
// sfx_tone_gen: square-wave effect tone, timed in written samples.
//   clk_i, reset_i  clock, synchronous active-high reset
//   start_i         (re)start: clear phase and duration, begin at +AMP
//   step_i          one effect sample was written this cycle
//   busy_o          tone is still running
//   done_o          this step writes off the final (LEN-th) sample
//   sample_o        current tone value, +AMP or -AMP
module sfx_tone_gen #(
  parameter int                  SAMPLE_W = 28,
  parameter logic [SAMPLE_W-1:0] AMP      = 28'h0200000,
  parameter int                  HALF     = 24,
  parameter int                  LEN      = 2400
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic                step_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [SAMPLE_W-1:0] sample_o
);

  localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int LW = (LEN > 1) ? $clog2(LEN) : 1;

  logic [HW-1:0] half_q, half_d;
  logic [LW-1:0] dur_q, dur_d;
  logic          neg_q, neg_d;
  logic          busy_q, busy_d;
  logic          last_half, last_dur, adv;

  assign last_half = (half_q == HW'(HALF - 1));
  assign last_dur  = (dur_q == LW'(LEN - 1));
  assign adv       = step_i && busy_q && !start_i;

  always_comb begin
    half_d = half_q;
    dur_d  = dur_q;
    neg_d  = neg_q;
    busy_d = busy_q;
    if (start_i) begin
      half_d = '0;
      dur_d  = '0;
      neg_d  = 1'b0;
      busy_d = 1'b1;
    end else if (adv) begin
      if (last_half) begin
        half_d = '0;
        neg_d  = ~neg_q;
      end else begin
        half_d = half_q + 1'b1;
      end
      if (last_dur) begin
        dur_d  = '0;
        busy_d = 1'b0;
      end else begin
        dur_d = dur_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      half_q <= '0;
      dur_q  <= '0;
      neg_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      half_q <= half_d;
      dur_q  <= dur_d;
      neg_q  <= neg_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = adv && last_dur;
  assign sample_o = neg_q ? (-AMP) : AMP;

endmodule

// File: rtl/audio_sample_arbiter.sv
// audio_sample_arbiter: schedules stereo samples into the codec write port,
// arbitrating crash > score > music, with effects as square-wave tones.
//   clk, reset                   clock, synchronous active-high reset
//   write_ready                  codec DAC FIFO has space
//   write                        one-cycle write strobe, at most every 2nd clock
//   writedata_left/right         sample (identical on both channels)
//   music_sample/valid/ready     music stream; ready pulses on write cycles with valid
//   score_evt, crash_evt         one-cycle effect triggers
//   game_over, mute              level controls that silence output
//   active_src                   0=music, 1=score, 2=crash
//   underrun_cnt                 saturating count of writes with music_valid low
// Build option: define AUDIO_MIX_EN to mix half-scale music under effects
// instead of letting effects fully preempt music.
module audio_sample_arbiter #(
  parameter int                  SAMPLE_W   = audio_pkg::SAMPLE_W,
  parameter logic [SAMPLE_W-1:0] AMP        = audio_pkg::AMP_DEF,
  parameter int                  SCORE_HALF = audio_pkg::SCORE_HALF_DEF,
  parameter int                  SCORE_LEN  = audio_pkg::SCORE_LEN_DEF,
  parameter int                  CRASH_HALF = audio_pkg::CRASH_HALF_DEF,
  parameter int                  CRASH_LEN  = audio_pkg::CRASH_LEN_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write_ready,
  output logic                write,
  output logic [SAMPLE_W-1:0] writedata_left,
  output logic [SAMPLE_W-1:0] writedata_right,
  input  logic [SAMPLE_W-1:0] music_sample,
  input  logic                music_valid,
  output logic                music_ready,
  input  logic                score_evt,
  input  logic                crash_evt,
  input  logic                game_over,
  input  logic                mute,
  output logic [1:0]          active_src,
  output logic [7:0]          underrun_cnt
);
  import audio_pkg::*;

  function automatic logic [7:0] sat_inc8(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

`ifdef AUDIO_MIX_EN
  function automatic logic signed [SAMPLE_W-1:0] half_s(input logic signed [SAMPLE_W-1:0] x);
    return x >>> 1;
  endfunction
`endif

  state_e                     state_q, state_d;
  logic                       write_q, write_d;
  logic [SAMPLE_W-1:0]        wdata_q, wdata_d;
  logic                       mready_q, mready_d;
  logic [7:0]                 under_q, under_d;
  logic                       wfx_q, wfx_d;

  logic                       issue;
  logic                       score_start, crash_start;
  logic                       score_step, crash_step;
  logic                       score_done, crash_done;
  logic                       score_busy, crash_busy;
  logic [SAMPLE_W-1:0]        score_smp, crash_smp;
  logic signed [SAMPLE_W-1:0] music_s, tone_s, fx_s, sel_s;

  // A write is issued on the edge that samples write_ready, and never from a
  // cycle that is already writing, so strobes are at least two clocks apart.
  assign issue = write_ready && !write_q;

  // Crash ignores all events; a same-cycle pair resolves to crash.
  assign crash_start = crash_evt && (state_q != S_CRASH);
  assign score_start = score_evt && !crash_evt && (state_q != S_CRASH);

  // wfx_q marks the in-flight write as a sample of the currently running tone.
  // A write issued on the same edge as a (re)start belongs to the old source
  // and must not advance the freshly cleared counters.
  assign wfx_d      = issue && (state_q != S_MUSIC) && !score_start && !crash_start;
  assign score_step = write_q && wfx_q && (state_q == S_SCORE);
  assign crash_step = write_q && wfx_q && (state_q == S_CRASH);

  sfx_tone_gen #(
    .SAMPLE_W(SAMPLE_W), .AMP(AMP), .HALF(SCORE_HALF), .LEN(SCORE_LEN)
  ) u_score (
    .clk_i(clk), .reset_i(reset), .start_i(score_start), .step_i(score_step),
    .busy_o(score_busy), .done_o(score_done), .sample_o(score_smp)
  );

  sfx_tone_gen #(
    .SAMPLE_W(SAMPLE_W), .AMP(AMP), .HALF(CRASH_HALF), .LEN(CRASH_LEN)
  ) u_crash (
    .clk_i(clk), .reset_i(reset), .start_i(crash_start), .step_i(crash_step),
    .busy_o(crash_busy), .done_o(crash_done), .sample_o(crash_smp)
  );

  // Effect FSM; tone exit happens on the edge that retires the last write.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_MUSIC: begin
        if (crash_start)      state_d = S_CRASH;
        else if (score_start) state_d = S_SCORE;
      end
      S_SCORE: begin
        if (crash_start)                     state_d = S_CRASH;
        else if (score_start)                state_d = S_SCORE;
        else if (score_done || !score_busy)  state_d = S_MUSIC;
      end
      S_CRASH: begin
        if (crash_done || !crash_busy) state_d = S_MUSIC;
      end
      default: state_d = S_MUSIC;
    endcase
  end

  // Sample selection, evaluated with the state seen at the issuing edge.
  assign music_s = music_valid ? music_sample : '0;
  assign tone_s  = (state_q == S_CRASH) ? crash_smp : score_smp;
`ifdef AUDIO_MIX_EN
  assign fx_s    = half_s(music_s) + half_s(tone_s);
`else
  assign fx_s    = tone_s;
`endif

  always_comb begin
    if (mute)                     sel_s = '0;
    else if (state_q != S_MUSIC)  sel_s = fx_s;
    else if (game_over)           sel_s = '0;
    else                          sel_s = music_s;
  end

  // Music is consumed on every write regardless of source, so tempo holds.
  always_comb begin
    write_d  = issue;
    wdata_d  = issue ? sel_s : wdata_q;
    mready_d = issue && music_valid;
    under_d  = (issue && !music_valid) ? sat_inc8(under_q) : under_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_MUSIC;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      mready_q <= 1'b0;
      under_q  <= '0;
      wfx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      mready_q <= mready_d;
      under_q  <= under_d;
      wfx_q    <= wfx_d;
    end
  end

  assign write           = write_q;
  assign writedata_left  = wdata_q;
  assign writedata_right = wdata_q;
  assign music_ready     = mready_q;
  assign active_src      = state_q;
  assign underrun_cnt    = under_q;

endmodule

// File: tb/tb_audio_sample_arbiter.sv
module tb_audio_sample_arbiter;

  localparam int SH = 2;
  localparam int SL = 6;
  localparam int CH = 3;
  localparam int CL = 9;
  localparam logic [27:0] POS = 28'd100;
  localparam logic [27:0] NEG = 28'(-100);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write_ready = 1'b0;
  logic        write;
  logic [27:0] writedata_left, writedata_right;
  logic [27:0] music_sample = '0;
  logic        music_valid = 1'b0;
  logic        music_ready;
  logic        score_evt = 1'b0;
  logic        crash_evt = 1'b0;
  logic        game_over = 1'b0;
  logic        mute = 1'b0;
  logic [1:0]  active_src;
  logic [7:0]  underrun_cnt;

  always #5 clk = ~clk;

  audio_sample_arbiter #(
    .SAMPLE_W(28), .AMP(28'd100),
    .SCORE_HALF(SH), .SCORE_LEN(SL), .CRASH_HALF(CH), .CRASH_LEN(CL)
  ) dut (
    .clk(clk), .reset(reset), .write_ready(write_ready), .write(write),
    .writedata_left(writedata_left), .writedata_right(writedata_right),
    .music_sample(music_sample), .music_valid(music_valid), .music_ready(music_ready),
    .score_evt(score_evt), .crash_evt(crash_evt), .game_over(game_over), .mute(mute),
    .active_src(active_src), .underrun_cnt(underrun_cnt)
  );

  int nchecks = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: effects are described by which tone is playing and how
  // many of its samples have been written; each effect instance gets an id so
  // a write belonging to an earlier instance is never counted against a new one.
  int          m_eff = 0, m_k = 0, m_gen = 0, m_pgen = 0, m_under = 0;
  bit          m_pfx = 0, m_write = 0, m_mready = 0;
  logic [27:0] m_data = '0;

  function automatic logic [27:0] tone_val(input int eff, input int k);
    int half;
    half = (eff == 2) ? CH : SH;
    return (((k / half) % 2) == 0) ? POS : NEG;
  endfunction

  task automatic model_edge();
    bit          issue;
    int          old_eff, old_gen, len;
    logic [27:0] mus, v;
    if (reset) begin
      m_eff = 0; m_k = 0; m_pfx = 0; m_write = 0; m_mready = 0;
      m_data = '0; m_under = 0;
      return;
    end
    old_eff = m_eff;
    old_gen = m_gen;
    issue = write_ready && !m_write;
    mus = music_valid ? music_sample : 28'd0;
    v = '0;
    if (mute)              v = '0;
    else if (m_eff != 0) begin
`ifdef AUDIO_MIX_EN
      v = ($signed(mus) >>> 1) + ($signed(tone_val(m_eff, m_k)) >>> 1);
`else
      v = tone_val(m_eff, m_k);
`endif
    end
    else if (game_over)    v = '0;
    else                   v = mus;

    if (m_eff != 2 && crash_evt) begin
      m_eff = 2; m_k = 0; m_gen++;
    end else if (m_eff != 2 && score_evt) begin
      m_eff = 1; m_k = 0; m_gen++;
    end else if (m_write && m_pfx && m_pgen == m_gen && m_eff != 0) begin
      m_k++;
      len = (m_eff == 2) ? CL : SL;
      if (m_k == len) begin m_eff = 0; m_k = 0; end
    end

    if (issue) begin
      m_pfx  = (old_eff != 0);
      m_pgen = old_gen;
      m_data = v;
    end
    m_write  = issue;
    m_mready = issue && music_valid;
    if (issue && !music_valid && m_under < 255) m_under++;
  endtask

  logic [27:0] wq[$];
  bit          prev_w = 0;
  bit          auto_smp = 0;

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("write", write, m_write);
    chk("wdata_l", writedata_left, m_data);
    chk("wdata_r", writedata_right, m_data);
    chk("mready", music_ready, m_mready);
    chk("src", active_src, m_eff);
    chk("underrun", underrun_cnt, m_under);
    if (write) begin
      chk("no_b2b", prev_w, 0);
      wq.push_back(writedata_left);
    end
    prev_w = write;
    if (auto_smp && m_mready) music_sample = music_sample + 28'd1;
  endtask

  task automatic run_until_writes(input int n, input int budget, input string nm);
    int c;
    c = 0;
    while (wq.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk({nm, "_budget"}, (wq.size() >= n), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1; score_evt = 0; crash_evt = 0; mute = 0; game_over = 0;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        sc;
    logic [27:0] smp;
    logic        w;
    logic [27:0] d;
    logic        mr;
    logic [1:0]  src;
  } vec_t;

  vec_t tbl[19];

  initial begin
    // Music then a score blip, cycle by cycle with hand-derived expectations.
    tbl[0]  = '{0, 28'd1, 1, 28'd1, 1, 0};
    tbl[1]  = '{0, 28'd1, 0, 28'd1, 0, 0};
    tbl[2]  = '{0, 28'd2, 1, 28'd2, 1, 0};
    tbl[3]  = '{0, 28'd2, 0, 28'd2, 0, 0};
    tbl[4]  = '{1, 28'd3, 1, 28'd3, 1, 1};
    tbl[5]  = '{0, 28'd3, 0, 28'd3, 0, 1};
    tbl[6]  = '{0, 28'd4, 1, POS,   1, 1};
    tbl[7]  = '{0, 28'd4, 0, POS,   0, 1};
    tbl[8]  = '{0, 28'd5, 1, POS,   1, 1};
    tbl[9]  = '{0, 28'd5, 0, POS,   0, 1};
    tbl[10] = '{0, 28'd6, 1, NEG,   1, 1};
    tbl[11] = '{0, 28'd6, 0, NEG,   0, 1};
    tbl[12] = '{0, 28'd7, 1, NEG,   1, 1};
    tbl[13] = '{0, 28'd7, 0, NEG,   0, 1};
    tbl[14] = '{0, 28'd8, 1, POS,   1, 1};
    tbl[15] = '{0, 28'd8, 0, POS,   0, 1};
    tbl[16] = '{0, 28'd9, 1, POS,   1, 1};
    tbl[17] = '{0, 28'd9, 0, POS,   0, 0};
    tbl[18] = '{0, 28'd10, 1, 28'd10, 1, 0};

    #1;
    do_reset();
    chk("rst_write", write, 0);
    chk("rst_data", writedata_left, 0);
    chk("rst_mready", music_ready, 0);
    chk("rst_src", active_src, 0);
    chk("rst_under", underrun_cnt, 0);

    write_ready = 1; music_valid = 1;
    for (int i = 0; i < 19; i++) begin
      score_evt = tbl[i].sc;
      music_sample = tbl[i].smp;
      tick();
      chk($sformatf("tbl%0d_w", i), write, tbl[i].w);
      chk($sformatf("tbl%0d_d", i), writedata_left, tbl[i].d);
      chk($sformatf("tbl%0d_mr", i), music_ready, tbl[i].mr);
      chk($sformatf("tbl%0d_src", i), active_src, tbl[i].src);
    end
    score_evt = 0;

    // Crash preempts a score blip two writes in; score during crash ignored.
    do_reset();
    auto_smp = 1; music_sample = 28'd1; write_ready = 1; music_valid = 1;
    score_evt = 1; tick(); score_evt = 0;
    wq.delete();
    run_until_writes(2, 20, "score2");
    chk("score_w0", wq[0], POS);
    chk("score_w1", wq[1], POS);
    crash_evt = 1; tick(); crash_evt = 0;
    chk("crash_src", active_src, 2);
    wq.delete();
    run_until_writes(4, 20, "crash4");
    score_evt = 1; tick(); score_evt = 0;
    chk("crash_ign_src", active_src, 2);
    run_until_writes(9, 40, "crash9");
    for (int i = 0; i < 9; i++)
      chk($sformatf("crash_w%0d", i), wq[i], ((i / 3) % 2 == 0) ? POS : NEG);
    tick();
    chk("crash_exit_src", active_src, 0);

    // Underruns: zero samples and a saturating counter.
    do_reset();
    auto_smp = 0; music_sample = 28'h123; write_ready = 1; music_valid = 0;
    wq.delete();
    run_until_writes(5, 30, "under5");
    for (int i = 0; i < 5; i++) chk($sformatf("under_w%0d", i), wq[i], 0);
    chk("under_cnt5", underrun_cnt, 5);
    run_until_writes(305, 1000, "under305");
    chk("under_sat", underrun_cnt, 255);

    // write_ready toggling: write only after a sampled ready, never back-to-back.
    do_reset();
    music_valid = 1;
    begin
      bit rp[8] = '{1, 0, 0, 1, 1, 0, 1, 0};
      bit wp[8] = '{1, 0, 0, 1, 0, 0, 1, 0};
      for (int i = 0; i < 8; i++) begin
        write_ready = rp[i];
        tick();
        chk($sformatf("rdy%0d_w", i), write, wp[i]);
      end
    end

    // Mute mid-crash, then game_over, then reset mid-effect.
    do_reset();
    auto_smp = 1; music_sample = 28'd50; write_ready = 1; music_valid = 1;
    crash_evt = 1; tick(); crash_evt = 0;
    wq.delete();
    run_until_writes(3, 20, "mute_pre");
    mute = 1;
    run_until_writes(6, 20, "mute_on");
    mute = 0;
    run_until_writes(9, 20, "mute_post");
    for (int i = 0; i < 9; i++)
      chk($sformatf("mute_w%0d", i), wq[i], (i >= 3 && i < 6) ? 28'd0 : POS);
    tick();
    chk("mute_exit_src", active_src, 0);
    game_over = 1;
    wq.delete();
    begin
      int mr;
      mr = 0;
      for (int c = 0; c < 40 && wq.size() < 3; c++) begin
        tick();
        if (music_ready) mr++;
      end
      chk("go_writes", wq.size(), 3);
      chk("go_mready", mr, 3);
      for (int i = 0; i < wq.size(); i++) chk($sformatf("go_w%0d", i), wq[i], 0);
    end
    game_over = 0;
    crash_evt = 1; tick(); crash_evt = 0;
    wq.delete();
    run_until_writes(2, 20, "rst_mid");
    write_ready = 1;
    reset = 1; tick(); reset = 0;
    chk("rstmid_write", write, 0);
    chk("rstmid_data", writedata_left, 0);
    chk("rstmid_mready", music_ready, 0);
    chk("rstmid_src", active_src, 0);
    chk("rstmid_under", underrun_cnt, 0);

    // Randomized traffic against the model.
    auto_smp = 0;
    for (int c = 0; c < 3000; c++) begin
      reset        = ($urandom_range(0, 499) == 0);
      write_ready  = ($urandom_range(0, 9) < 7);
      music_valid  = ($urandom_range(0, 9) < 8);
      music_sample = 28'($urandom());
      score_evt    = ($urandom_range(0, 99) < 3);
      crash_evt    = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 49) == 0) mute = ~mute;
      if ($urandom_range(0, 49) == 0) game_over = ~game_over;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
